bcd_bin_seq: RTL and testbench
==============================

# bcd_bin_seq

Sequential multi-digit BCD-to-binary converter, the inverse of the team's binary-to-BCD block. It accepts a packed BCD word on a start pulse and folds it into a binary value one digit per clock, using the update acc = acc*10 + digit. It sits downstream of BCD keypad or display paths and feeds binary arithmetic.

## Interface
- DIGITS, default 3: number of BCD digits converted per request.
- BIN_W, default 10: binary result width. Must satisfy 2^BIN_W ≥ 10^DIGITS. The range is not checked in RTL.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only while busy=0.
- bcd  input  4*DIGITS  packed BCD word; bcd[3:0] is the least significant digit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin/err are updated.
- bin  output  BIN_W  binary result; held until the next done.
- err  output  1  invalid-digit flag; held with bin.

## Operation
- The FSM has two states: IDLE and CONV.
- IDLE:
  - busy=0.
  - On start=1, latch bcd into an internal shift register, clear acc, load the digit counter with DIGITS-1, and go to CONV.
  - Clear the error accumulator at the same time.
- CONV:
  - Each cycle, take the top nibble d of the shift register and set acc <= acc*10 + d.
  - Compute the product at BIN_W+4 bits, then truncate to BIN_W.
  - Shift the register left by 4 and decrement the counter.
  - Record d>9 in the error accumulator (only when BCD_BIN_ERR_EN is defined).
- When the counter reaches 0 in CONV, the last digit is processed, then:
  - Register bin and err from the final acc and error accumulator.
  - Pulse done for one cycle.
  - Return to IDLE.
- start while busy=1 is ignored. It is neither queued nor allowed to corrupt the in-flight conversion.
- bcd is sampled only on the accepting edge. Changes afterwards have no effect.
- bin and err keep their value from the previous conversion while a new one runs. They change only on the done cycle.
- DIGITS=1 is legal: a single CONV cycle.

## Timing
- Reset values: busy=0, done=0, bin=0, err=0. FSM returns to IDLE; internal acc, shift register and counter are cleared.
- Accept edge E0 (start=1, busy=0): busy=1 from E0.
- Conversion edges are E1..E_DIGITS. On E_DIGITS:
  - done=1, busy=0.
  - bin and err take their new values.
- Latency: done is observed DIGITS cycles after the accepting cycle (3 cycles at default). Throughput is one conversion per DIGITS+1 cycles, including the accept cycle.
- Back-to-back: start may be asserted in the cycle where done=1. It is accepted because busy=0, and done drops on the next edge.
- Reset asserted mid-conversion:
  - Aborts immediately and asynchronously.
  - No done pulse follows.
  - bin and err go to 0.
- After rst_n deasserts, the first start is accepted normally.

## Configuration
- Macro BCD_BIN_ERR_EN.
- Defined:
  - Any latched nibble >9 sets err=1 at done.
  - bin is forced to 0 for that conversion.
  - err clears on the next valid conversion.
- Undefined:
  - err is tied to 0.
  - No digit checking is done.
  - Nibbles >9 are folded arithmetically: bin = Σ d_i*10^i mod 2^BIN_W.

## Test plan
- Default params, reset, then start with bcd=12'h999 -> done 3 cycles later, bin=999 (10'b1111100111), err=0, busy high for exactly 3 cycles.
- bcd=12'h407 -> bin=407 (10'h197). Then bcd=12'h000 with start asserted in the done cycle -> second done exactly 3 cycles later, bin=0.
- Start bcd=12'h250, assert start with bcd=12'h123 on every cycle while busy -> single done, bin=250. Extra starts are ignored.
- With BCD_BIN_ERR_EN defined, bcd=12'h1A3 -> err=1, bin=0. A following conversion of 12'h005 -> err=0, bin=5. Without the macro, 12'h1A3 -> bin=1*100+10*10+3=203, err=0.
- Start bcd=12'h876, pull rst_n low after 1 conversion cycle -> bin=0, busy=0, done never pulses. Release and convert 12'h876 -> bin=876.
- DIGITS=1, BIN_W=4: bcd=4'h7 -> done 1 cycle after accept, bin=7.

Source files
------------

// File: rtl/bcd_bin_seq.sv
// bcd_bin_seq: sequential BCD-to-binary converter, one digit per clock
// using acc = acc*10 + digit, most significant digit first.
// Optional feature macro: BCD_BIN_ERR_EN. When it is defined, nibbles
// greater than 9 are flagged on err and force bin to 0 for that conversion.
// When it is undefined, err stays 0 and such nibbles are folded arithmetically.
module bcd_bin_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin,
  output logic                err
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned PROD_W = BIN_W + 4;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state;
  logic [BCD_W-1:0]   sreg;
  logic [BIN_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         dig;
  logic [BIN_W-1:0]   acc_nxt;

  // Current digit is the top nibble of the shift register
  assign dig = sreg[BCD_W-1 -: 4];

  // Multiply-accumulate at BIN_W+4 bits, truncated back to BIN_W
  assign acc_nxt = BIN_W'(PROD_W'(acc) * PROD_W'(10) + PROD_W'(dig));

`ifdef BCD_BIN_ERR_EN
  logic err_acc;
  logic err_nxt;

  // Sticky invalid-digit flag including the digit processed this cycle
  assign err_nxt = err_acc | (dig > 4'd9);
`endif

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin     <= '0;
      err     <= 1'b0;
`ifdef BCD_BIN_ERR_EN
      err_acc <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= bcd;
            acc     <= '0;
            cnt     <= CNT_W'(DIGITS - 1);
            busy    <= 1'b1;
            state   <= CONV;
`ifdef BCD_BIN_ERR_EN
            err_acc <= 1'b0;
`endif
          end
        end
        CONV: begin
          acc  <= acc_nxt;
          sreg <= sreg << 4;
          cnt  <= cnt - CNT_W'(1);
`ifdef BCD_BIN_ERR_EN
          err_acc <= err_nxt;
`endif
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef BCD_BIN_ERR_EN
            bin   <= err_nxt ? '0 : acc_nxt;
            err   <= err_nxt;
`else
            bin   <= acc_nxt;
            err   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Directed bench for bcd_bin_seq: default 3-digit instance plus a 1-digit one.
module tb_bcd_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic        busy, done, err;
  logic [9:0]  bin;

  logic        start1;
  logic [3:0]  bcd1;
  logic        busy1, done1, err1;
  logic [3:0]  bin1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_bin_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
    .busy(busy), .done(done), .bin(bin), .err(err)
  );

  bcd_bin_seq #(.DIGITS(1), .BIN_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bcd(bcd1),
    .busy(busy1), .done(done1), .bin(bin1), .err(err1)
  );

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one request on the 3-digit instance and step past the accept edge
  task automatic start_conv(input logic [11:0] v, input string tag);
    bcd   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
  endtask

  // Wait for done (bounded), optionally hammering start, then check results
  task automatic wait_done(input logic [9:0] eb, input logic ee, input logic hammer,
                           input logic [9:0] held, input string tag);
    int cyc = 1;
    while (!done && cyc < 20) begin
      check({tag, "_busy_during"}, 32'(busy), 32'd1);
      check({tag, "_bin_held"}, 32'(bin), 32'(held));
      if (hammer) begin
        start = 1'b1;
        bcd   = 12'h123;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc - 1), 32'd3);
    check({tag, "_bin"}, 32'(bin), 32'(eb));
    check({tag, "_err"}, 32'(err), 32'(ee));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [9:0] exp_1a3_bin;
    logic       exp_1a3_err;
    int         lat1;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd    = '0;
    start1 = 1'b0;
    bcd1   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin",  32'(bin),  32'd0);
    check("rst_err",  32'(err),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-scale value
    start_conv(12'h999, "c999");
    wait_done(10'd999, 1'b0, 1'b0, 10'd0, "c999");
    @(negedge clk);

    // 407, then back-to-back start issued in the done cycle
    start_conv(12'h407, "c407");
    wait_done(10'd407, 1'b0, 1'b0, 10'd999, "c407");
    start_conv(12'h000, "c000");
    check("b2b_done_dropped", 32'(done), 32'd0);
    wait_done(10'd0, 1'b0, 1'b0, 10'd407, "c000");
    @(negedge clk);

    // Starts while busy are ignored
    start_conv(12'h250, "c250");
    wait_done(10'd250, 1'b0, 1'b1, 10'd0, "c250");
    repeat (4) begin
      @(negedge clk);
      check("c250_no_extra_done", 32'(done), 32'd0);
      check("c250_idle", 32'(busy), 32'd0);
    end

    // Invalid digit handling depends on build configuration
`ifdef BCD_BIN_ERR_EN
    exp_1a3_bin = 10'd0;
    exp_1a3_err = 1'b1;
`else
    exp_1a3_bin = 10'd203;
    exp_1a3_err = 1'b0;
`endif
    start_conv(12'h1A3, "c1a3");
    wait_done(exp_1a3_bin, exp_1a3_err, 1'b0, 10'd250, "c1a3");
    @(negedge clk);
    start_conv(12'h005, "c005");
    wait_done(10'd5, 1'b0, 1'b0, exp_1a3_bin, "c005");
    @(negedge clk);

    // Reset mid-conversion aborts without done
    start_conv(12'h876, "c876a");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_bin",  32'(bin),  32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_conv(12'h876, "c876b");
    wait_done(10'd876, 1'b0, 1'b0, 10'd0, "c876b");
    @(negedge clk);

    // Single-digit instance: done one cycle after accept
    bcd1   = 4'h7;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bcd1   = 4'h2;
    check("d1_busy", 32'(busy1), 32'd1);
    lat1 = 0;
    while (!done1 && lat1 < 10) begin
      @(negedge clk);
      lat1++;
    end
    check("d1_latency", 32'(lat1), 32'd1);
    check("d1_bin", 32'(bin1), 32'd7);
    check("d1_err", 32'(err1), 32'd0);
    check("d1_idle", 32'(busy1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
